pc_sequencer: RTL and testbench

Parametrised program-counter sequencer: the next-generation PC register for the processor datapath. It holds the current instruction address and adds the following behaviour:
- configurable width, step and reset vector;
- edge-qualified increment (one step per `incPC` assertion);
- absolute jump, PC-relative branch, and call/return through an internal return-address stack (RAS).

It sits between the control unit (which issues `incPC` and ops) and the memory address path (which consumes `PC_Output`).

---
 rtl/pc_pkg.sv | 13 +
 rtl/return_stack.sv | 52 +++++
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encodings and defaults for the PC sequencer
package pc_pkg;

  localparam int PC_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    PC_OP_JUMP   = 2'b00,
    PC_OP_BRANCH = 2'b01,
    PC_OP_CALL   = 2'b10,
    PC_OP_RET    = 2'b11
  } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - parametrised LIFO holding return addresses
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Requests on a full/empty stack, or both at once, leave the stack untouched;
  // the owner decides how that is reported.
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end else if (do_pop) begin
      count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AW'(count_q)] <= push_data;
    end
  end

  assign top   = mem[AW'(count_q - 1'b1)];
  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with edge-qualified increment, jump, branch and call/return
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_DEFAULT_WIDTH,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           incPC,
  input  logic                           op_valid,
  input  logic [1:0]                     op,
  input  logic [WIDTH-1:0]               target,
  output logic [WIDTH-1:0]               PC_Output,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_full,
  output logic                           ras_empty,
  output logic                           ras_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             armed_q;
  logic             err_q;
  logic             err_set;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ras_top;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (clr),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + STEP_W),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (op_valid) begin
      case (pc_op_t'(op))
        PC_OP_JUMP:   pc_d = target;
        PC_OP_BRANCH: pc_d = pc_q + target;
        PC_OP_CALL: begin
          pc_d = target;
          if (ras_full) err_set = 1'b1;
          else          push    = 1'b1;
        end
        PC_OP_RET: begin
          if (ras_empty) begin
            err_set = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end else if (incPC && armed_q) begin
      pc_d = pc_q + STEP_W;
    end
  end

  // A high incPC always leaves the flag cleared (consumed by an increment or
  // an op, or already spent); a low incPC always re-arms it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q    <= RESET_VECTOR;
      armed_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      armed_q <= !incPC;
      err_q   <= err_q | err_set;
    end
  end

  assign PC_Output = pc_q;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          incPC = 1'b0;
  logic          op_valid = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  target = '0;
  logic [W-1:0]  PC_Output;
  logic [1:0]    ras_count;
  logic          ras_full;
  logic          ras_empty;
  logic          ras_err;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  pc_sequencer #(
    .WIDTH        (W),
    .STEP         (1),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .incPC     (incPC),
    .op_valid  (op_valid),
    .op        (op),
    .target    (target),
    .PC_Output (PC_Output),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void compare(exp_t e);
    chk($sformatf("v%0d pc", e.idx), PC_Output, e.pc);
    chk($sformatf("v%0d ras_count", e.idx), 32'(ras_count), 32'(e.cnt));
    chk($sformatf("v%0d ras_full", e.idx), 32'(ras_full), 32'(e.cnt == 2'(DEPTH)));
    chk($sformatf("v%0d ras_empty", e.idx), 32'(ras_empty), 32'(e.cnt == 2'd0));
    chk($sformatf("v%0d ras_err", e.idx), 32'(ras_err), 32'(e.err));
  endfunction

  // Monitor: anything queued before an edge is the response to that edge.
  initial begin
    int n;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      @(negedge clk);
      if (n > 0) compare(exp_q.pop_front());
    end
  end

  // Called at negedge+1; returns at the following negedge+1.
  task automatic step(input logic inc, input logic v, input logic [1:0] o,
                      input logic [31:0] tgt, input logic [31:0] epc,
                      input logic [1:0] ecnt, input logic eerr);
    exp_t e;
    incPC    = inc;
    op_valid = v;
    op       = o;
    target   = tgt;
    e.idx = vec; e.pc = epc; e.cnt = ecnt; e.err = eerr;
    vec++;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] epc, input logic [1:0] ecnt, input logic eerr);
    step(1'b0, 1'b0, 2'b00, 32'h0, epc, ecnt, eerr);
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e.idx = vec; e.pc = 32'h100; e.cnt = 2'd0; e.err = 1'b0;
    vec++;
    chk({tag, " rv"}, PC_Output, 32'h100);
    compare(e);
  endtask

  task automatic pulse_clr(input string tag);
    incPC = 1'b0; op_valid = 1'b0;
    clr = 1'b0;
    #1;
    check_reset(tag);
    #1 clr = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset("por");
    clr = 1'b1;

    // incPC high 5, low 1, high 1
    step(1, 0, 2'b00, 0, 32'h101, 0, 0);
    repeat (4) step(1, 0, 2'b00, 0, 32'h101, 0, 0);
    idle(32'h101, 0, 0);
    step(1, 0, 2'b00, 0, 32'h102, 0, 0);
    idle(32'h102, 0, 0);

    // branch negative/positive, jump to max then wrap
    step(0, 1, PC_OP_JUMP,   32'h40,       32'h40, 0, 0);
    step(0, 1, PC_OP_BRANCH, 32'hFFFFFFF0, 32'h30, 0, 0);
    step(0, 1, PC_OP_BRANCH, 32'h10,       32'h40, 0, 0);
    step(0, 1, PC_OP_JUMP,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    step(1, 0, 2'b00, 0, 32'h0, 0, 0);
    idle(32'h0, 0, 0);

    // call overflow then returns, then back-to-back call/ret
    step(0, 1, PC_OP_JUMP, 32'h10,  32'h10,  0, 0);
    step(0, 1, PC_OP_CALL, 32'h200, 32'h200, 1, 0);
    step(0, 1, PC_OP_CALL, 32'h300, 32'h300, 2, 0);
    step(0, 1, PC_OP_CALL, 32'h400, 32'h400, 2, 1);
    step(0, 1, PC_OP_RET,  32'h0,   32'h201, 1, 1);
    step(0, 1, PC_OP_RET,  32'h0,   32'h11,  0, 1);
    step(0, 1, PC_OP_CALL, 32'h500, 32'h500, 1, 1);
    step(0, 1, PC_OP_RET,  32'h0,   32'h12,  0, 1);
    pulse_clr("clr1");

    // underflow is sticky until clr
    step(0, 1, PC_OP_JUMP, 32'h50, 32'h50, 0, 0);
    step(0, 1, PC_OP_RET,  32'h0,  32'h50, 0, 1);
    idle(32'h50, 0, 1);
    idle(32'h50, 0, 1);
    pulse_clr("clr2");

    // op wins over a rising incPC and consumes it
    step(1, 1, PC_OP_JUMP, 32'h80, 32'h80, 0, 0);
    step(1, 0, 2'b00, 0, 32'h80, 0, 0);
    idle(32'h80, 0, 0);
    step(1, 0, 2'b00, 0, 32'h81, 0, 0);
    idle(32'h81, 0, 0);

    // async clr between edges after three calls
    step(0, 1, PC_OP_CALL, 32'h600, 32'h600, 1, 0);
    step(0, 1, PC_OP_CALL, 32'h700, 32'h700, 2, 0);
    step(0, 1, PC_OP_CALL, 32'h800, 32'h800, 2, 1);
    pulse_clr("async");
    idle(32'h100, 0, 0);
    step(1, 0, 2'b00, 0, 32'h101, 0, 0);

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
